// File: rtl/gate_result_checker.sv
// Response checker for the bitwise AND/OR gate blocks: accepts an operand pair,
// waits SETTLE cycles, compares the DUT result buses against a|b and a&b.
module gate_result_checker #(
   parameter int WIDTH  = 3,
   parameter int SETTLE = 2,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             vec_valid,
   output logic             vec_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [WIDTH-1:0] or_res,
   input  logic [WIDTH-1:0] and_res,
   output logic             chk_valid,
   output logic             chk_pass,
   output logic [WIDTH-1:0] mism_or,
   output logic [WIDTH-1:0] mism_and,
   output logic [CNT_W-1:0] vec_count,
   output logic [CNT_W-1:0] err_count,
   output logic             err_sticky
);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   localparam logic [7:0]       SETTLE_M1 = 8'(SETTLE - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t           state, state_nxt;
   logic [7:0]       settle_cnt, settle_cnt_nxt;
   logic [WIDTH-1:0] a_q, b_q;
   logic             load, sample;
   logic [WIDTH-1:0] mism_or_nxt, mism_and_nxt;
   logic             fail_nxt;

   // Expected values derive only from the latched operands, never from a_in/b_in.
   assign mism_or_nxt  = or_res  ^ (a_q | b_q);
   assign mism_and_nxt = and_res ^ (a_q & b_q);
   assign fail_nxt     = (|mism_or_nxt) | (|mism_and_nxt);

   always_comb begin
      state_nxt      = state;
      settle_cnt_nxt = settle_cnt;
      load           = 1'b0;
      sample         = 1'b0;
      vec_ready      = 1'b0;
      unique case (state)
         S_IDLE: begin
            vec_ready = ~clear;
            if (vec_valid && !clear) begin
               load           = 1'b1;
               settle_cnt_nxt = SETTLE_M1;
               state_nxt      = S_WAIT;
            end
         end
         S_WAIT: begin
            if (settle_cnt != 8'd0) begin
               settle_cnt_nxt = settle_cnt - 8'd1;
            end else begin
               sample    = ~clear;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (clear) state_nxt = S_IDLE;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of the order the tool evaluates them in.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         settle_cnt <= 8'd0;
      end else begin
         state      <= state_nxt;
         settle_cnt <= settle_cnt_nxt;
      end
   end

   // NOTE: the operand latches carry no reset; they are only read in S_WAIT,
   // which is always entered through a load.
   always_ff @(posedge clk) begin
      if (load) begin
         a_q <= a_in;
         b_q <= b_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         chk_valid  <= 1'b0;
         chk_pass   <= 1'b0;
         mism_or    <= '0;
         mism_and   <= '0;
         vec_count  <= '0;
         err_count  <= '0;
         err_sticky <= 1'b0;
      end else if (clear) begin
         chk_valid  <= 1'b0;
         vec_count  <= '0;
         err_count  <= '0;
         err_sticky <= 1'b0;
      end else begin
         chk_valid <= sample;
         if (sample) begin
            mism_or  <= mism_or_nxt;
            mism_and <= mism_and_nxt;
            chk_pass <= ~fail_nxt;
            if (vec_count != CNT_MAX) vec_count <= vec_count + 1'b1;
            if (fail_nxt) begin
               err_sticky <= 1'b1;
               if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_gate_result_checker.sv
// Directed table-driven bench for gate_result_checker, plus abort and
// counter-saturation sequences on a second narrow-counter instance.
module tb_gate_result_checker;

   localparam int WIDTH  = 3;
   localparam int SETTLE = 2;
   localparam int CNT_W  = 8;

   logic             clk = 1'b0;
   logic             rst, clear, vec_valid;
   logic [WIDTH-1:0] a_in, b_in, or_res, and_res;

   logic             vec_ready, chk_valid, chk_pass, err_sticky;
   logic [WIDTH-1:0] mism_or, mism_and;
   logic [CNT_W-1:0] vec_count, err_count;

   logic             s_vec_ready, s_chk_valid, s_chk_pass, s_err_sticky;
   logic [WIDTH-1:0] s_mism_or, s_mism_and;
   logic [1:0]       s_vec_count, s_err_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   gate_result_checker #(.WIDTH(WIDTH), .SETTLE(SETTLE), .CNT_W(CNT_W)) u_dut (
      .clk(clk), .rst(rst), .clear(clear), .vec_valid(vec_valid), .vec_ready(vec_ready),
      .a_in(a_in), .b_in(b_in), .or_res(or_res), .and_res(and_res),
      .chk_valid(chk_valid), .chk_pass(chk_pass), .mism_or(mism_or), .mism_and(mism_and),
      .vec_count(vec_count), .err_count(err_count), .err_sticky(err_sticky)
   );

   gate_result_checker #(.WIDTH(WIDTH), .SETTLE(SETTLE), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .clear(clear), .vec_valid(vec_valid), .vec_ready(s_vec_ready),
      .a_in(a_in), .b_in(b_in), .or_res(or_res), .and_res(and_res),
      .chk_valid(s_chk_valid), .chk_pass(s_chk_pass), .mism_or(s_mism_or),
      .mism_and(s_mism_and), .vec_count(s_vec_count), .err_count(s_err_count),
      .err_sticky(s_err_sticky)
   );

   typedef struct {
      logic [2:0] a, b;          // operands at acceptance
      logic [2:0] a_late, b_late; // operands driven during the wait
      logic [2:0] o, n;          // DUT OR / AND result buses
      logic       pass;
      logic [2:0] m_or, m_and;
      int         vc, ec;
      logic       sticky;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Starts just after a falling edge; returns at the falling edge after the result pulse.
   task automatic apply(input vec_t v);
      a_in = v.a; b_in = v.b; or_res = v.o; and_res = v.n; vec_valid = 1'b1;
      #1 check("ready_before_accept", vec_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      vec_valid = 1'b0; a_in = v.a_late; b_in = v.b_late;
      check("ready_in_wait", vec_ready, 1'b0);
      check("valid_after_accept", chk_valid, 1'b0);
      for (int i = 1; i < SETTLE; i++) begin
         @(negedge clk);
         check("valid_early", chk_valid, 1'b0);
      end
      @(negedge clk);
      check("valid_pulse", chk_valid, 1'b1);
      check("ready_after_check", vec_ready, 1'b1);
      check("chk_pass", chk_pass, v.pass);
      check("mism_or", mism_or, v.m_or);
      check("mism_and", mism_and, v.m_and);
   endtask

   initial begin
      vec_t v;
      tbl[0] = '{a:3'b000, b:3'b000, a_late:3'b000, b_late:3'b000, o:3'b000, n:3'b000,
                 pass:1, m_or:3'b000, m_and:3'b000, vc:1, ec:0, sticky:0};
      tbl[1] = '{a:3'b100, b:3'b100, a_late:3'b100, b_late:3'b100, o:3'b100, n:3'b100,
                 pass:1, m_or:3'b000, m_and:3'b000, vc:2, ec:0, sticky:0};
      tbl[2] = '{a:3'b100, b:3'b010, a_late:3'b100, b_late:3'b010, o:3'b110, n:3'b000,
                 pass:1, m_or:3'b000, m_and:3'b000, vc:3, ec:0, sticky:0};
      tbl[3] = '{a:3'b111, b:3'b111, a_late:3'b111, b_late:3'b111, o:3'b111, n:3'b111,
                 pass:1, m_or:3'b000, m_and:3'b000, vc:4, ec:0, sticky:0};
      tbl[4] = '{a:3'b111, b:3'b111, a_late:3'b111, b_late:3'b111, o:3'b111, n:3'b000,
                 pass:0, m_or:3'b000, m_and:3'b111, vc:5, ec:1, sticky:1};
      tbl[5] = '{a:3'b100, b:3'b010, a_late:3'b100, b_late:3'b010, o:3'b110, n:3'b000,
                 pass:1, m_or:3'b000, m_and:3'b000, vc:6, ec:1, sticky:1};
      tbl[6] = '{a:3'b100, b:3'b100, a_late:3'b111, b_late:3'b111, o:3'b100, n:3'b100,
                 pass:1, m_or:3'b000, m_and:3'b000, vc:7, ec:1, sticky:1};
      tbl[7] = '{a:3'b011, b:3'b101, a_late:3'b011, b_late:3'b101, o:3'b101, n:3'b001,
                 pass:0, m_or:3'b010, m_and:3'b000, vc:8, ec:2, sticky:1};

      rst = 1'b1; clear = 1'b0; vec_valid = 1'b0;
      a_in = '0; b_in = '0; or_res = '0; and_res = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Idle after reset.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle_chk_valid", chk_valid, 1'b0);
         check("idle_vec_ready", vec_ready, 1'b1);
      end
      check("rst_chk_pass", chk_pass, 1'b0);
      check("rst_mism_or", mism_or, 3'b000);
      check("rst_mism_and", mism_and, 3'b000);
      check("rst_vec_count", vec_count, 8'd0);
      check("rst_err_count", err_count, 8'd0);
      check("rst_err_sticky", err_sticky, 1'b0);

      // Back-to-back vectors, fault injection and late operand change.
      for (int i = 0; i < 8; i++) begin
         apply(tbl[i]);
         check("vec_count", vec_count, tbl[i].vc);
         check("err_count", err_count, tbl[i].ec);
         check("err_sticky", err_sticky, tbl[i].sticky);
         check("sat_vec_count", s_vec_count, (tbl[i].vc > 3) ? 3 : tbl[i].vc);
         check("sat_err_count", s_err_count, (tbl[i].ec > 3) ? 3 : tbl[i].ec);
      end

      // Clear on the sampling edge discards the check; results are retained.
      a_in = 3'b111; b_in = 3'b111; or_res = 3'b111; and_res = 3'b111; vec_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vec_valid = 1'b0;
      for (int i = 1; i < SETTLE; i++) @(negedge clk);
      clear = 1'b1;
      #1 check("clear_vec_ready", vec_ready, 1'b0);
      @(negedge clk);
      check("clear_no_pulse", chk_valid, 1'b0);
      check("clear_vec_count", vec_count, 8'd0);
      check("clear_err_count", err_count, 8'd0);
      check("clear_err_sticky", err_sticky, 1'b0);
      check("clear_ready_held", vec_ready, 1'b0);
      check("clear_keeps_pass", chk_pass, 1'b0);
      check("clear_keeps_mism_or", mism_or, 3'b010);
      clear = 1'b0;
      #1 check("unclear_vec_ready", vec_ready, 1'b1);
      for (int i = 0; i < SETTLE + 1; i++) begin
         @(negedge clk);
         check("post_clear_no_pulse", chk_valid, 1'b0);
      end

      // Reset one cycle after a handshake drops the pending check.
      vec_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vec_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < SETTLE + 2; i++) begin
         @(negedge clk);
         check("rst_abort_no_pulse", chk_valid, 1'b0);
      end
      check("rst_abort_vec_count", vec_count, 8'd0);
      check("rst_abort_ready", vec_ready, 1'b1);

      // Seven failing vectors: the 2-bit counters saturate at 3.
      v = '{a:3'b111, b:3'b111, a_late:3'b111, b_late:3'b111, o:3'b111, n:3'b000,
            pass:0, m_or:3'b000, m_and:3'b111, vc:0, ec:0, sticky:1};
      for (int i = 0; i < 7; i++) apply(v);
      check("sat_vec_count_final", s_vec_count, 2'd3);
      check("sat_err_count_final", s_err_count, 2'd3);
      check("sat_err_sticky", s_err_sticky, 1'b1);
      check("sat_chk_valid", s_chk_valid, 1'b1);
      check("sat_chk_pass", s_chk_pass, 1'b0);
      check("sat_mism_or", s_mism_or, 3'b000);
      check("sat_mism_and", s_mism_and, 3'b111);
      check("sat_vec_ready", s_vec_ready, 1'b1);
      check("wide_vec_count", vec_count, 8'd7);
      check("wide_err_count", err_count, 8'd7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
